f_pc_unit: RTL and testbench
============================

// Module: f_pc_unit
// PURPOSE
//  Fetch-stage program counter. Holds the current fetch PC and computes the next one,
//  choosing between sequential flow, a D-stage branch/jump, an ERET return and
//  exception entry. It drives F-stage exception detection with pc and is_eret_aft,
//  and drives the F/D register with bd.
//  It sits between the hazard unit, D-stage branch logic, CP0 and the IM / F-exception logic.
// PARAMETERS
//  RESET_PC   32'h0000_3000  PC value loaded on reset
//  EXC_ENTRY  32'h0000_4180  exception/interrupt handler entry
// PORTS
//  clk          in   1   system clock
//  reset        in   1   synchronous, active-low reset
//  stall        in   1   hazard-unit stall; hold PC
//  d_is_jump    in   1   instr in D is a branch/jump (F instr is its delay slot)
//  br_taken     in   1   D-stage branch/jump resolved taken
//  br_target    in   32  D-stage branch/jump target
//  eret_req     in   1   ERET in D stage
//  epc          in   32  CP0 EPC value
//  exc_req      in   1   CP0 exception/interrupt taken this cycle
//  pc           out  32  current fetch PC (to IM and F exception check)
//  is_eret_aft  out  1   F instr is the wrong-path fetch after an ERET; suppress its exception
//  bd           out  1   F instr is a branch delay slot
//  fetch_cnt    out  32  valid fetches retired from F (only with F_FETCH_CNT_EN)
// BEHAVIOUR
//  - Reset (reset==0 at posedge): pc<=RESET_PC; eret_pend<=0; fetch_cnt<=0.
//    Reset has priority over every request.
//  - Next-PC priority, applied at posedge:
//    1. exc_req -> EXC_ENTRY. Ignores stall; cancels a pending ERET.
//    2. stall -> hold pc.
//    3. eret_req -> epc. ERET has no delay slot.
//    4. br_taken -> br_target.
//    5. otherwise pc+4, mod 2^32. 32'hFFFF_FFFC wraps to 0; no trap here.
//  - epc and br_target are not aligned or range-checked here. A bad PC propagates to pc
//    and is flagged downstream as AdEL.
//  - eret_pend register:
//    - Set in the cycle where eret_req=1, stall=0 and exc_req=0.
//    - The pc loaded in that cycle is the return target, so the flag must NOT mark it.
//    - Cleared on the next unstalled cycle or on exc_req.
//  - is_eret_aft = eret_req & ~exc_req. Combinational.
//    - Marks the sequential instruction currently in F, which is discarded next cycle.
//    - Stays 1 while the ERET is stalled in D.
//  - bd = d_is_jump & ~eret_req. Combinational. Valid in the same cycle as pc.
//  - Latency:
//    - A redirect request in cycle N gives the new pc in cycle N+1.
//    - exc_req and eret_req in the same cycle -> EXC_ENTRY.
//    - br_taken and eret_req together is illegal; ERET wins.
//    - stall with br_taken or eret_req: the request must persist until the first
//      unstalled cycle. No request is latched internally.
//  - An exc_req during a stall still redirects, and clears any ERET effect for that cycle.
// CONFIGURATION
//  F_FETCH_CNT_EN defined:
//    - fetch_cnt port exists.
//    - Increments by 1 on every cycle with reset=1, stall=0, exc_req=0 and is_eret_aft=0.
//    - Saturates at 32'hFFFF_FFFF.
//  F_FETCH_CNT_EN undefined:
//    - Port and counter logic are absent.
//    - All other behaviour is identical.
// TESTING
//  T1 reset=0 for 2 cycles, then 3 free cycles -> pc 3000,3000,3004,3008,300C.
//     fetch_cnt=3 with the macro defined.
//  T2 pc=3010 with d_is_jump=1, br_taken=1, br_target=3400 -> bd=1 this cycle;
//     next pc=3400.
//  T3 stall=1 for 2 cycles at pc=3020, br_taken held -> pc stays 3020;
//     pc=br_target in the cycle after stall drops.
//  T4 eret_req=1, epc=3100 at pc=3050 -> is_eret_aft=1 that cycle; next pc=3100
//     with is_eret_aft=0. Repeat with exc_req=1 in the same cycle -> pc=4180.
//  T5 stall=1 and exc_req=1 -> pc=4180 next cycle. epc=3001 via ERET -> pc=3001,
//     passed unchanged.
//  T6 Force pc=FFFF_FFFC via branch target, then 1 free cycle -> pc=0000_0000.
//     reset=0 mid-branch -> pc=3000.

Source files
------------

// File: rtl/f_pc_unit.sv
// ---------------------------------------------------------------------------
// f_pc_unit -- fetch-stage program counter
//
// Holds the current fetch PC and selects the next one. From highest to lowest
// priority the choices are: exception entry, stall (hold), ERET return to EPC,
// taken D-stage branch/jump target, and the sequential pc+4.
// It also flags the F instruction fetched behind an ERET (is_eret_aft), so its
// exception is suppressed. It flags an F instruction sitting in a branch delay
// slot (bd).
//
// Optional feature macro: F_FETCH_CNT_EN
//   When defined, adds the fetch_cnt output. This is a saturating count of
//   valid fetches retired from F.
//
// Ports
//   clk          in   1   system clock
//   reset        in   1   synchronous, active-low reset
//   stall        in   1   hazard-unit stall; hold PC
//   d_is_jump    in   1   instr in D is a branch/jump (F instr is its delay slot)
//   br_taken     in   1   D-stage branch/jump resolved taken
//   br_target    in   32  D-stage branch/jump target
//   eret_req     in   1   ERET in D stage
//   epc          in   32  CP0 EPC value
//   exc_req      in   1   CP0 exception/interrupt taken this cycle
//   pc           out  32  current fetch PC
//   is_eret_aft  out  1   F instr is the wrong-path fetch after an ERET
//   bd           out  1   F instr is a branch delay slot
//   fetch_cnt    out  32  valid fetches retired from F (F_FETCH_CNT_EN only)
// ---------------------------------------------------------------------------
module f_pc_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        d_is_jump,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        eret_req,
  input  logic [31:0] epc,
  input  logic        exc_req,
  output logic [31:0] pc,
  output logic        is_eret_aft,
  output logic        bd
`ifdef F_FETCH_CNT_EN
  ,
  output logic [31:0] fetch_cnt
`endif
);

  logic [31:0] next_pc;
  logic        eret_pend;

  // An exception redirects even while stalled. ERET outranks a branch
  // because ERET has no delay slot. Sequential flow wraps at 2^32.
  always_comb begin
    next_pc = pc + 32'd4;
    if (exc_req) begin
      next_pc = EXC_ENTRY;
    end else if (stall) begin
      next_pc = pc;
    end else if (eret_req) begin
      next_pc = epc;
    end else if (br_taken) begin
      next_pc = br_target;
    end
  end

  // Requests held off by a stall are not latched here. The requester keeps
  // them asserted until the first unstalled cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc <= RESET_PC;
    end else begin
      pc <= next_pc;
    end
  end

  // eret_pend is set when an ERET actually redirects. It then covers the
  // cycle in which the return target sits in F. It is cleared on the next
  // unstalled cycle, and an exception cancels it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      eret_pend <= 1'b0;
    end else if (exc_req) begin
      eret_pend <= 1'b0;
    end else if (!stall) begin
      eret_pend <= eret_req;
    end
  end

  // eret_pend has no consumer inside this block. It is kept as visible state
  // for debug.
  logic unused_eret_pend;
  assign unused_eret_pend = eret_pend;

  // The F instruction behind an ERET in D is wrong-path, and so is its
  // exception. This is driven from the live request, not from eret_pend, so
  // the return target itself is never marked.
  assign is_eret_aft = eret_req & ~exc_req;
  assign bd          = d_is_jump & ~eret_req;

`ifdef F_FETCH_CNT_EN
  // Counts only cycles where the F instruction really moves on. The count
  // saturates instead of wrapping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_cnt <= 32'd0;
    end else if (!stall && !exc_req && !is_eret_aft && (fetch_cnt != 32'hFFFF_FFFF)) begin
      fetch_cnt <= fetch_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_f_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_f_pc_unit -- directed self-checking bench for f_pc_unit.
// Inputs are driven 1 time unit after each rising edge. Outputs are sampled
// after the inputs settle, which keeps all sampling away from the clock edge.
// ---------------------------------------------------------------------------
module tb_f_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        d_is_jump;
  logic        br_taken;
  logic [31:0] br_target;
  logic        eret_req;
  logic [31:0] epc;
  logic        exc_req;
  logic [31:0] pc;
  logic        is_eret_aft;
  logic        bd;
`ifdef F_FETCH_CNT_EN
  logic [31:0] fetch_cnt;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  f_pc_unit dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .d_is_jump   (d_is_jump),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .eret_req    (eret_req),
    .epc         (epc),
    .exc_req     (exc_req),
    .pc          (pc),
    .is_eret_aft (is_eret_aft),
    .bd          (bd)
`ifdef F_FETCH_CNT_EN
    ,
    .fetch_cnt   (fetch_cnt)
`endif
  );

  // Advance one clock and land 1 time unit past the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall     = 1'b0;
    d_is_jump = 1'b0;
    br_taken  = 1'b0;
    br_target = 32'h0;
    eret_req  = 1'b0;
    epc       = 32'h0;
    exc_req   = 1'b0;
  endtask

  // Redirect through a taken branch so a test can start from a chosen pc.
  task automatic jump_to(input logic [31:0] target);
    br_taken  = 1'b1;
    br_target = target;
    tick();
    clear_inputs();
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b0;
    tick();
    n_checks++;
    if (pc !== 32'h0000_3000) begin
      n_fails++;
      $display("[TB] FAIL reset_cycle1: got %h expected %h", pc, 32'h0000_3000);
    end
    n_checks++;
    if (bd !== 1'b0 || is_eret_aft !== 1'b0) begin
      n_fails++;
      $display("[TB] FAIL reset_flags: got bd=%b aft=%b expected 0 0", bd, is_eret_aft);
    end
    tick();
    n_checks++;
    if (pc !== 32'h0000_3000) begin
      n_fails++;
      $display("[TB] FAIL reset_cycle2: got %h expected %h", pc, 32'h0000_3000);
    end
    reset = 1'b1;
    tick();
    n_checks++;
    if (pc !== 32'h0000_3004) begin
      n_fails++;
      $display("[TB] FAIL seq_1: got %h expected %h", pc, 32'h0000_3004);
    end
    tick();
    n_checks++;
    if (pc !== 32'h0000_3008) begin
      n_fails++;
      $display("[TB] FAIL seq_2: got %h expected %h", pc, 32'h0000_3008);
    end
    tick();
    n_checks++;
    if (pc !== 32'h0000_300C) begin
      n_fails++;
      $display("[TB] FAIL seq_3: got %h expected %h", pc, 32'h0000_300C);
    end
`ifdef F_FETCH_CNT_EN
    n_checks++;
    if (fetch_cnt !== 32'd3) begin
      n_fails++;
      $display("[TB] FAIL fetch_cnt_after_reset: got %0d expected 3", fetch_cnt);
    end
`endif
  endtask

  task automatic test_branch();
    tick();
    n_checks++;
    if (pc !== 32'h0000_3010) begin
      n_fails++;
      $display("[TB] FAIL branch_setup: got %h expected %h", pc, 32'h0000_3010);
    end
    d_is_jump = 1'b1;
    br_taken  = 1'b1;
    br_target = 32'h0000_3400;
    #1;
    n_checks++;
    if (bd !== 1'b1) begin
      n_fails++;
      $display("[TB] FAIL branch_bd: got %b expected 1", bd);
    end
    tick();
    clear_inputs();
    n_checks++;
    if (pc !== 32'h0000_3400) begin
      n_fails++;
      $display("[TB] FAIL branch_target: got %h expected %h", pc, 32'h0000_3400);
    end
  endtask

  task automatic test_stall();
    jump_to(32'h0000_3020);
    stall     = 1'b1;
    br_taken  = 1'b1;
    br_target = 32'h0000_3200;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (pc !== 32'h0000_3020) begin
        n_fails++;
        $display("[TB] FAIL stall_hold_%0d: got %h expected %h", i, pc, 32'h0000_3020);
      end
    end
    stall = 1'b0;
    tick();
    clear_inputs();
    n_checks++;
    if (pc !== 32'h0000_3200) begin
      n_fails++;
      $display("[TB] FAIL stall_release: got %h expected %h", pc, 32'h0000_3200);
    end
  endtask

  task automatic test_eret();
    jump_to(32'h0000_3050);
    eret_req  = 1'b1;
    epc       = 32'h0000_3100;
    d_is_jump = 1'b1;
    #1;
    n_checks++;
    if (is_eret_aft !== 1'b1 || bd !== 1'b0) begin
      n_fails++;
      $display("[TB] FAIL eret_flags: got aft=%b bd=%b expected 1 0", is_eret_aft, bd);
    end
    tick();
    clear_inputs();
    #1;
    n_checks++;
    if (pc !== 32'h0000_3100 || is_eret_aft !== 1'b0) begin
      n_fails++;
      $display("[TB] FAIL eret_return: got pc=%h aft=%b expected 00003100 0", pc, is_eret_aft);
    end
    tick();
    // Stalled ERET: the flag stays up and pc holds.
    stall    = 1'b1;
    eret_req = 1'b1;
    epc      = 32'h0000_3300;
    tick();
    n_checks++;
    if (pc !== 32'h0000_3104 || is_eret_aft !== 1'b1) begin
      n_fails++;
      $display("[TB] FAIL eret_stalled: got pc=%h aft=%b expected 00003104 1", pc, is_eret_aft);
    end
    stall   = 1'b0;
    exc_req = 1'b1;
    #1;
    n_checks++;
    if (is_eret_aft !== 1'b0) begin
      n_fails++;
      $display("[TB] FAIL eret_exc_flag: got %b expected 0", is_eret_aft);
    end
    tick();
    clear_inputs();
    n_checks++;
    if (pc !== 32'h0000_4180) begin
      n_fails++;
      $display("[TB] FAIL eret_exc_pc: got %h expected %h", pc, 32'h0000_4180);
    end
  endtask

  task automatic test_stall_exc();
    tick();
    stall   = 1'b1;
    exc_req = 1'b1;
    tick();
    clear_inputs();
    n_checks++;
    if (pc !== 32'h0000_4180) begin
      n_fails++;
      $display("[TB] FAIL stall_exc: got %h expected %h", pc, 32'h0000_4180);
    end
    eret_req = 1'b1;
    epc      = 32'h0000_3001;
    tick();
    clear_inputs();
    n_checks++;
    if (pc !== 32'h0000_3001) begin
      n_fails++;
      $display("[TB] FAIL eret_unaligned: got %h expected %h", pc, 32'h0000_3001);
    end
    tick();
    n_checks++;
    if (pc !== 32'h0000_3005) begin
      n_fails++;
      $display("[TB] FAIL unaligned_seq: got %h expected %h", pc, 32'h0000_3005);
    end
  endtask

  task automatic test_wrap();
    jump_to(32'hFFFF_FFFC);
    n_checks++;
    if (pc !== 32'hFFFF_FFFC) begin
      n_fails++;
      $display("[TB] FAIL wrap_setup: got %h expected %h", pc, 32'hFFFF_FFFC);
    end
    tick();
    n_checks++;
    if (pc !== 32'h0000_0000) begin
      n_fails++;
      $display("[TB] FAIL wrap: got %h expected %h", pc, 32'h0000_0000);
    end
    br_taken  = 1'b1;
    br_target = 32'h0000_5000;
    exc_req   = 1'b1;
    reset     = 1'b0;
    tick();
    clear_inputs();
    reset = 1'b1;
    n_checks++;
    if (pc !== 32'h0000_3000) begin
      n_fails++;
      $display("[TB] FAIL reset_mid_branch: got %h expected %h", pc, 32'h0000_3000);
    end
  endtask

  initial begin
    reset = 1'b0;
    clear_inputs();
    #1;
    test_reset();
    test_branch();
    test_stall();
    test_eret();
    test_stall_exc();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
